// File: rtl/multicycle_ctrl_unit.sv
// multicycle_ctrl_unit
//   Multi-cycle instruction sequencer for the ATMega32A core control block.
//   It sits beside the single-cycle decoder and watches the decoded
//   instruction_id. For LPM, LD, ST, CALL and RET it stalls fetch, runs a
//   cycle counter and holds the class enable strobes for the whole
//   instruction. It pulses instr_done once when the instruction completes.
//
//   Optional feature macro: CTRL_WAITSTATE_EN
//     defined   -> a mem_ready port exists. The last cycle of an instruction
//                  is stretched until mem_ready=1.
//     undefined -> there is no mem_ready port. Latency is fixed at N cycles.
//
// Ports
//   clk              core clock
//   reset_n          synchronous active-low reset
//   instruction_id   decoded instruction (0 = NOP)
//   instr_valid      instruction_id is valid this cycle
//   flush            abort the in-flight instruction / block acceptance
//   mem_ready        memory ready (only with CTRL_WAITSTATE_EN)
//   LPM_enable       program-memory read strobe
//   dmem_rd_enable   data-memory read strobe (LD, RET)
//   dmem_wr_enable   data-memory write strobe (ST, CALL)
//   stack_enable     SP update strobe (CALL, RET)
//   stall            hold PC/fetch
//   clock_counter    cycle index within the current instruction
//   instr_done       one-cycle completion pulse
//
// state | meaning
// IDLE  | no multi-cycle instruction in flight, accepting new IDs
// EXEC  | instruction in flight, counter running, strobes held
module multicycle_ctrl_unit #(
  parameter int unsigned      ID_W     = 8,
  parameter int unsigned      CNT_W    = 4,
  parameter logic [ID_W-1:0]  ID_LPM   = 8'h22,
  parameter logic [ID_W-1:0]  ID_LD    = 8'h20,
  parameter logic [ID_W-1:0]  ID_ST    = 8'h21,
  parameter logic [ID_W-1:0]  ID_CALL  = 8'h30,
  parameter logic [ID_W-1:0]  ID_RET   = 8'h31,
  parameter int unsigned      LPM_CYC  = 3,
  parameter int unsigned      LDST_CYC = 2,
  parameter int unsigned      STK_CYC  = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [ID_W-1:0]  instruction_id,
  input  logic             instr_valid,
  input  logic             flush,
`ifdef CTRL_WAITSTATE_EN
  input  logic             mem_ready,
`endif
  output logic             LPM_enable,
  output logic             dmem_rd_enable,
  output logic             dmem_wr_enable,
  output logic             stack_enable,
  output logic             stall,
  output logic [CNT_W-1:0] clock_counter,
  output logic             instr_done
);

  typedef enum logic {IDLE, EXEC} state_t;

  // The last counter value of each class is N-1.
  localparam logic [CNT_W-1:0] LPM_LAST  = CNT_W'(LPM_CYC - 1);
  localparam logic [CNT_W-1:0] LDST_LAST = CNT_W'(LDST_CYC - 1);
  localparam logic [CNT_W-1:0] STK_LAST  = CNT_W'(STK_CYC - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] last_q;
  logic [3:0]       strb_q;   // {lpm, dmem_rd, dmem_wr, stack}
  logic             stall_q;
  logic             done_q;

  logic             hit_d;
  logic [3:0]       strb_d;
  logic [CNT_W-1:0] last_d;
  logic             mem_rdy;

`ifdef CTRL_WAITSTATE_EN
  assign mem_rdy = mem_ready;
`else
  assign mem_rdy = 1'b1;
`endif

  // Decode the incoming ID into a strobe pattern and a final count.
  always_comb begin
    hit_d  = 1'b1;
    strb_d = 4'b0000;
    last_d = '0;
    if (instruction_id == ID_LPM) begin
      strb_d = 4'b1000;
      last_d = LPM_LAST;
    end else if (instruction_id == ID_LD) begin
      strb_d = 4'b0100;
      last_d = LDST_LAST;
    end else if (instruction_id == ID_ST) begin
      strb_d = 4'b0010;
      last_d = LDST_LAST;
    end else if (instruction_id == ID_CALL) begin
      strb_d = 4'b0011;
      last_d = STK_LAST;
    end else if (instruction_id == ID_RET) begin
      strb_d = 4'b0101;
      last_d = STK_LAST;
    end else begin
      hit_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      last_q  <= '0;
      strb_q  <= 4'b0000;
      stall_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (instr_valid && !flush && hit_d) begin
            state_q <= EXEC;
            cnt_q   <= CNT_W'(1);
            last_q  <= last_d;
            strb_q  <= strb_d;
            stall_q <= 1'b1;
          end else begin
            cnt_q   <= '0;
            strb_q  <= 4'b0000;
            stall_q <= 1'b0;
          end
        end
        EXEC: begin
          if (flush) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            strb_q  <= 4'b0000;
            stall_q <= 1'b0;
            done_q  <= 1'b0;
          end else if (cnt_q == last_q) begin
            // The final cycle holds here while memory is not ready.
            if (mem_rdy) begin
              state_q <= IDLE;
              cnt_q   <= '0;
              strb_q  <= 4'b0000;
              stall_q <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
          strb_q  <= 4'b0000;
          stall_q <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign LPM_enable     = strb_q[3];
  assign dmem_rd_enable = strb_q[2];
  assign dmem_wr_enable = strb_q[1];
  assign stack_enable   = strb_q[0];
  assign stall          = stall_q;
  assign clock_counter  = cnt_q;
  assign instr_done     = done_q;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] instruction_id = 8'h00;
  logic       instr_valid = 1'b0;
  logic       flush = 1'b0;
`ifdef CTRL_WAITSTATE_EN
  logic       mem_ready = 1'b1;
`endif
  logic       LPM_enable, dmem_rd_enable, dmem_wr_enable, stack_enable;
  logic       stall, instr_done;
  logic [3:0] clock_counter;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multicycle_ctrl_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .instruction_id (instruction_id),
    .instr_valid    (instr_valid),
    .flush          (flush),
`ifdef CTRL_WAITSTATE_EN
    .mem_ready      (mem_ready),
`endif
    .LPM_enable     (LPM_enable),
    .dmem_rd_enable (dmem_rd_enable),
    .dmem_wr_enable (dmem_wr_enable),
    .stack_enable   (stack_enable),
    .stall          (stall),
    .clock_counter  (clock_counter),
    .instr_done     (instr_done)
  );

  // Packed output word: {lpm, rd, wr, stk, stall, cnt[3:0], done}
  function automatic logic [9:0] ex(input logic lpm, input logic rd, input logic wr,
                                    input logic stk, input logic stl,
                                    input logic [3:0] cnt, input logic dn);
    return {lpm, rd, wr, stk, stl, cnt, dn};
  endfunction

  function automatic logic [9:0] got();
    return {LPM_enable, dmem_rd_enable, dmem_wr_enable, stack_enable,
            stall, clock_counter, instr_done};
  endfunction

  task automatic check(input string name, input logic [9:0] exp);
    logic [9:0] g;
    g = got();
    checks++;
    if (g !== exp) begin
      errors++;
      $display("FAIL %s got=%b exp=%b (lpm rd wr stk stall cnt4 done)", name, g, exp);
    end
  endtask

  task automatic check_int(input string name, input int g, input int exp);
    checks++;
    if (g != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", name, g, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic       rn;
    logic       vld;
    logic [7:0] id;
    logic       fl;
    logic [9:0] exp;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  // Issue one instruction and count the stall cycles until instr_done.
  task automatic run_count(input string name, input logic [7:0] id, input int exp_stall);
    int stl_cyc;
    int done_cnt;
    bit seen;
    stl_cyc  = 0;
    done_cnt = 0;
    seen     = 0;
    @(negedge clk);
    instruction_id = id;
    instr_valid    = 1'b1;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (stall) stl_cyc++;
      if (instr_done) begin
        done_cnt++;
        seen = 1;
      end
      @(negedge clk);
      instr_valid = 1'b0;
    end
    check_int({name, "_stall_cycles"}, stl_cyc, exp_stall);
    check_int({name, "_done_seen"}, done_cnt, 1);
    @(posedge clk);
    #1;
    check({name, "_after"}, ex(0,0,0,0,0,4'd0,0));
  endtask

  initial begin
    vecs[0]  = '{"rst0",      0, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[1]  = '{"rst1",      0, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[2]  = '{"lpm_c1",    1, 1, 8'h22, 0, ex(1,0,0,0,1,4'd1,0)};
    vecs[3]  = '{"lpm_c2",    1, 1, 8'h22, 0, ex(1,0,0,0,1,4'd2,0)};
    vecs[4]  = '{"lpm_done",  1, 0, 8'h22, 0, ex(0,0,0,0,0,4'd0,1)};
    vecs[5]  = '{"lpm_idle",  1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[6]  = '{"nop",       1, 1, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[7]  = '{"unknown",   1, 1, 8'h7F, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[8]  = '{"invalid",   1, 0, 8'h22, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[9]  = '{"flush_idl", 1, 1, 8'h22, 1, ex(0,0,0,0,0,4'd0,0)};
    vecs[10] = '{"call_c1",   1, 1, 8'h30, 0, ex(0,0,1,1,1,4'd1,0)};
    vecs[11] = '{"call_c2",   1, 1, 8'h30, 0, ex(0,0,1,1,1,4'd2,0)};
    vecs[12] = '{"call_c3",   1, 1, 8'h30, 0, ex(0,0,1,1,1,4'd3,0)};
    vecs[13] = '{"call_done", 1, 1, 8'h20, 0, ex(0,0,0,0,0,4'd0,1)};
    vecs[14] = '{"ld_b2b_c1", 1, 1, 8'h20, 0, ex(0,1,0,0,1,4'd1,0)};
    vecs[15] = '{"ld_done",   1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,1)};
    vecs[16] = '{"ld_idle",   1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[17] = '{"ret_c1",    1, 1, 8'h31, 0, ex(0,1,0,1,1,4'd1,0)};
    vecs[18] = '{"ret_flush", 1, 1, 8'h31, 1, ex(0,0,0,0,0,4'd0,0)};
    vecs[19] = '{"ret_nodone",1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[20] = '{"st_c1",     1, 1, 8'h21, 0, ex(0,0,1,0,1,4'd1,0)};
    vecs[21] = '{"st_done",   1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,1)};
    vecs[22] = '{"lpm2_c1",   1, 1, 8'h22, 0, ex(1,0,0,0,1,4'd1,0)};
    vecs[23] = '{"lpm2_c2",   1, 1, 8'h22, 0, ex(1,0,0,0,1,4'd2,0)};
    vecs[24] = '{"rst_mid0",  0, 1, 8'h22, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[25] = '{"rst_mid1",  0, 1, 8'h22, 0, ex(0,0,0,0,0,4'd0,0)};
    vecs[26] = '{"post_rst",  1, 0, 8'h00, 0, ex(0,0,0,0,0,4'd0,0)};

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      reset_n        = vecs[i].rn;
      instr_valid    = vecs[i].vld;
      instruction_id = vecs[i].id;
      flush          = vecs[i].fl;
      @(posedge clk);
      #1;
      check(vecs[i].name, vecs[i].exp);
    end

    @(negedge clk);
    instr_valid = 1'b0;
    flush       = 1'b0;
    run_count("ret", 8'h31, 3);
    run_count("st",  8'h21, 1);
    run_count("lpm", 8'h22, 2);

`ifdef CTRL_WAITSTATE_EN
    begin
      int stl_cyc;
      int done_cnt;
      stl_cyc  = 0;
      done_cnt = 0;
      @(negedge clk);
      instruction_id = 8'h22;
      instr_valid    = 1'b1;
      mem_ready      = 1'b0;
      @(posedge clk); #1;
      check("ws_c1", ex(1,0,0,0,1,4'd1,0));
      if (stall) stl_cyc++;
      @(negedge clk);
      instr_valid = 1'b0;
      @(posedge clk); #1;
      check("ws_c2", ex(1,0,0,0,1,4'd2,0));
      if (stall) stl_cyc++;
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check("ws_hold", ex(1,0,0,0,1,4'd2,0));
        if (stall) stl_cyc++;
        if (instr_done) done_cnt++;
      end
      @(negedge clk);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      check("ws_done", ex(0,0,0,0,0,4'd0,1));
      if (instr_done) done_cnt++;
      @(posedge clk); #1;
      check("ws_idle", ex(0,0,0,0,0,4'd0,0));
      if (instr_done) done_cnt++;
      check_int("ws_stall_cycles", stl_cyc, 5);
      check_int("ws_done_count", done_cnt, 1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
